openeth_mem_arb: RTL and testbench

- Two-requester arbiter that shares the single Avalon memory master of the Ethernet MAC wrapper between requester 0 (MAC buffer-descriptor DMA) and requester 1 (a second bus master, e.g. a checksum/copy engine).
- Sits between the requesters and the system interconnect.
- Round-robin arbitration with registered grant and bounded hold (burst) length.
- Optional watchdog that aborts a stalled transfer.

---
 rtl/openeth_pkg.sv | 21 ++
 rtl/openeth_mem_arb_if.sv | 21 ++
 rtl/openeth_rr_pick.sv | 13 +
 rtl/openeth_mem_arb.sv | 133 +++++++++++++
 tb/tb_openeth_mem_arb.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/openeth_pkg.sv
// Shared types for the Ethernet MAC memory-arbiter slice: arbiter state,
// the Avalon request bundle and the watchdog abort data pattern.
package openeth_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  localparam logic [31:0] ARB_ABORT_DATA = 32'hDEADBEEF;

  typedef struct packed {
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic        read;
    logic        write;
    logic [31:0] writedata;
  } av_req_t;

endpackage

// File: rtl/openeth_mem_arb_if.sv
// Non-pipelined Avalon link; master drives the request, slave returns
// read data and waitrequest.
interface openeth_mem_arb_if;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, byteenable, read, write, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/openeth_rr_pick.sv
// Combinational two-way round-robin selector: on contention the requester
// that did not own the bus last wins.
module openeth_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       pick,
  output logic       valid
);

  assign valid = |req;
  assign pick  = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/openeth_mem_arb.sv
// Two-requester round-robin arbiter for the shared Avalon memory master,
// with bounded burst length. Define OPENETH_ARB_WDOG_EN to add the stall watchdog.
module openeth_mem_arb
  import openeth_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  openeth_mem_arb_if.slave         r0,
  openeth_mem_arb_if.slave         r1,
  openeth_mem_arb_if.master        m,
  output logic                     r0_err,
  output logic                     r1_err,
  output logic [1:0]               grant
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  arb_state_e    state, state_nxt;
  logic          last, last_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  av_req_t       req0, req1, sel;
  logic          own, own_req, complete, abort;
  logic          pick, pick_vld;

  assign req0 = {r0.address, r0.byteenable, r0.read, r0.write, r0.writedata};
  assign req1 = {r1.address, r1.byteenable, r1.read, r1.write, r1.writedata};

  openeth_rr_pick u_pick (
    .req   ({req1.read | req1.write, req0.read | req0.write}),
    .last  (last),
    .pick  (pick),
    .valid (pick_vld)
  );

  assign own      = (state == ARB_OWN1);
  assign sel      = own ? req1 : req0;
  assign own_req  = (state != ARB_IDLE) && (sel.read || sel.write);
  assign complete = own_req && !m.waitrequest;

`ifdef OPENETH_ARB_WDOG_EN
  logic [15:0] wdog;

  assign abort = own_req && m.waitrequest && (wdog == 16'(TIMEOUT - 1));

  // Counts stalled cycles of the current owner; any progress or release clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog <= '0;
    end else if (own_req && m.waitrequest && !abort) begin
      wdog <= (wdog == 16'hFFFF) ? wdog : wdog + 16'd1;
    end else begin
      wdog <= '0;
    end
  end
`else
  logic unused_timeout;

  assign abort          = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_comb begin
    m.address      = '0;
    m.byteenable   = '0;
    m.read         = 1'b0;
    m.write        = 1'b0;
    m.writedata    = '0;
    r0.waitrequest = 1'b1;
    r1.waitrequest = 1'b1;
    r0.readdata    = '0;
    r1.readdata    = '0;
    r0_err         = 1'b0;
    r1_err         = 1'b0;
    grant          = 2'b00;
    if (state != ARB_IDLE) begin
      m.address    = sel.address;
      m.byteenable = sel.byteenable;
      m.read       = sel.read & ~abort;
      m.write      = sel.write & ~abort;
      m.writedata  = sel.writedata;
      grant        = own ? 2'b10 : 2'b01;
      if (own) begin
        r1.waitrequest = m.waitrequest & ~abort;
        r1.readdata    = abort ? ARB_ABORT_DATA : m.readdata;
        r1_err         = abort;
      end else begin
        r0.waitrequest = m.waitrequest & ~abort;
        r0.readdata    = abort ? ARB_ABORT_DATA : m.readdata;
        r0_err         = abort;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    burst_nxt = burst_cnt;
    case (state)
      ARB_IDLE: begin
        burst_nxt = '0;
        if (pick_vld) state_nxt = pick ? ARB_OWN1 : ARB_OWN0;
      end
      ARB_OWN0, ARB_OWN1: begin
        last_nxt = own;
        if (!own_req || abort) begin
          state_nxt = ARB_IDLE;
        end else if (complete) begin
          // Limit is checked before incrementing so the counter never wraps.
          if (burst_cnt == BURST_LAST) state_nxt = ARB_IDLE;
          else                         burst_nxt = burst_cnt + 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARB_IDLE;
      last      <= 1'b1;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      burst_cnt <= burst_nxt;
    end
  end

endmodule

// File: tb/tb_openeth_mem_arb.sv
// Self-checking bench for openeth_mem_arb (MAX_BURST=4, TIMEOUT=8); completions
// are matched against a scoreboard of expected transfers.
module tb_openeth_mem_arb;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       r0_err, r1_err;
  logic [1:0] grant;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    logic        owner;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  openeth_mem_arb_if r0_if ();
  openeth_mem_arb_if r1_if ();
  openeth_mem_arb_if m_if ();

  openeth_mem_arb #(.MAX_BURST(4), .TIMEOUT(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .r0      (r0_if),
    .r1      (r1_if),
    .m       (m_if),
    .r0_err  (r0_err),
    .r1_err  (r1_err),
    .grant   (grant)
  );

  // Scoreboard: every completed bus cycle must match the oldest expected transfer.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] rd;
    if (reset_n && (m_if.read || m_if.write) && !m_if.waitrequest) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: completion addr=%h grant=%b, none expected", m_if.address, grant);
      end else begin
        e = sb.pop_front();
        if (grant !== (e.owner ? 2'b10 : 2'b01) || m_if.address !== e.addr ||
            m_if.write !== e.wr || (e.wr && m_if.writedata !== e.wdata)) begin
          errors++;
          $display("FAIL sb_xfer: got grant=%b addr=%h wr=%b wd=%h, expected owner=%0d addr=%h wr=%b wd=%h",
                   grant, m_if.address, m_if.write, m_if.writedata, e.owner, e.addr, e.wr, e.wdata);
        end
        if (!e.wr) begin
          checks++;
          rd = e.owner ? r1_if.readdata : r0_if.readdata;
          if (rd !== e.rdata) begin
            errors++;
            $display("FAIL sb_rdata: got %h expected %h", rd, e.rdata);
          end
        end
      end
    end
  end

  task automatic drive(input int n, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (n == 0) begin
      r0_if.read = rd; r0_if.write = wr; r0_if.address = a; r0_if.writedata = d; r0_if.byteenable = 4'hF;
    end else begin
      r1_if.read = rd; r1_if.write = wr; r1_if.address = a; r1_if.writedata = d; r1_if.byteenable = 4'hF;
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    m_if.waitrequest = 1'b0;
    m_if.readdata = 32'hCAFEF00D;
    drive(0, 1, 0, 32'h0000_0040, 32'h1234_0000);
    drive(1, 0, 1, 32'h0000_0080, 32'h5678_0000);
    @(negedge clk);
    checks++;
    if ({m_if.read, m_if.write} !== 2'b00) begin errors++; $display("FAIL reset_rw: got %b expected 00", {m_if.read, m_if.write}); end
    checks++;
    if (m_if.address !== 32'h0 || m_if.writedata !== 32'h0 || m_if.byteenable !== 4'h0) begin
      errors++; $display("FAIL reset_mbus: got a=%h wd=%h be=%h expected zeros", m_if.address, m_if.writedata, m_if.byteenable);
    end
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
    checks++;
    if ({r0_if.waitrequest, r1_if.waitrequest} !== 2'b11) begin
      errors++; $display("FAIL reset_wait: got %b expected 11", {r0_if.waitrequest, r1_if.waitrequest});
    end
    checks++;
    if ({r0_err, r1_err} !== 2'b00 || r0_if.readdata !== 32'h0 || r1_if.readdata !== 32'h0) begin
      errors++; $display("FAIL reset_resp: got err=%b rd0=%h rd1=%h expected zeros", {r0_err, r1_err}, r0_if.readdata, r1_if.readdata);
    end
    step();
  endtask

  task automatic test_single;
    logic [1:0] eg;
    apply_reset();
    m_if.waitrequest = 1'b1;
    drive(0, 0, 1, 32'h100, 32'hA5A5_0001);
    sb.push_back('{1'b0, 32'h100, 1'b1, 32'hA5A5_0001, 32'h0});
    for (int c = 1; c <= 7; c++) begin
      if (c == 5) m_if.waitrequest = 1'b0;
      if (c == 6) drive(0, 0, 0, 0, 0);
      @(negedge clk);
      eg = (c == 1 || c == 7) ? 2'b00 : 2'b01;
      checks++;
      if (grant !== eg) begin errors++; $display("FAIL single_grant c%0d: got %b expected %b", c, grant, eg); end
      checks++;
      if (m_if.write !== (c >= 2 && c <= 5)) begin errors++; $display("FAIL single_mwrite c%0d: got %b", c, m_if.write); end
      if (c >= 2 && c <= 5) begin
        checks++;
        if (m_if.address !== 32'h100) begin errors++; $display("FAIL single_addr c%0d: got %h expected 100", c, m_if.address); end
      end
      if (c != 6) begin
        checks++;
        if (r0_if.waitrequest !== (c != 5)) begin errors++; $display("FAIL single_wait c%0d: got %b", c, r0_if.waitrequest); end
      end
      step();
    end
  endtask

  task automatic test_contention;
    logic [1:0] eg [5] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
    apply_reset();
    m_if.waitrequest = 1'b0;
    m_if.readdata = 32'h1234_5678;
    drive(0, 1, 0, 32'h200, 0);
    drive(1, 1, 0, 32'h300, 0);
    sb.push_back('{1'b0, 32'h200, 1'b0, 32'h0, 32'h1234_5678});
    sb.push_back('{1'b1, 32'h300, 1'b0, 32'h0, 32'h1234_5678});
    for (int c = 1; c <= 5; c++) begin
      if (c == 3) drive(0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (grant !== eg[c-1]) begin errors++; $display("FAIL cont_grant c%0d: got %b expected %b", c, grant, eg[c-1]); end
      checks++;
      if (m_if.read !== (c == 2 || c == 5)) begin errors++; $display("FAIL cont_mread c%0d: got %b", c, m_if.read); end
      if (c < 5) begin
        checks++;
        if (r1_if.waitrequest !== 1'b1 || r1_if.readdata !== 32'h0) begin
          errors++; $display("FAIL cont_r1_isol c%0d: got wait=%b rd=%h expected 1/0", c, r1_if.waitrequest, r1_if.readdata);
        end
      end
      step();
    end
    drive(1, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_burst;
    logic [1:0] eg [18] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10,
                            2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01};
    int n0 = 0;
    int n1 = 0;
    apply_reset();
    m_if.waitrequest = 1'b0;
    m_if.readdata = 32'h0B0B_0B0B;
    for (int k = 0; k < 4; k++)  sb.push_back('{1'b0, 32'h1000 + 32'(4*k), 1'b0, 32'h0, 32'h0B0B_0B0B});
    for (int k = 0; k < 4; k++)  sb.push_back('{1'b1, 32'h2000 + 32'(4*k), 1'b0, 32'h0, 32'h0B0B_0B0B});
    for (int k = 4; k < 10; k++) sb.push_back('{1'b0, 32'h1000 + 32'(4*k), 1'b0, 32'h0, 32'h0B0B_0B0B});
    for (int c = 0; c < 18; c++) begin
      drive(0, n0 < 10, 0, 32'h1000 + 32'(4*n0), 0);
      drive(1, n1 < 4, 0, 32'h2000 + 32'(4*n1), 0);
      @(negedge clk);
      checks++;
      if (grant !== eg[c]) begin errors++; $display("FAIL burst_grant c%0d: got %b expected %b", c+1, grant, eg[c]); end
      if (r0_if.read && !r0_if.waitrequest) n0++;
      if (r1_if.read && !r1_if.waitrequest) n1++;
      step();
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    checks++;
    if (n0 != 10 || n1 != 4) begin errors++; $display("FAIL burst_count: got r0=%0d r1=%0d expected 10/4", n0, n1); end
    step();
    step();
  endtask

  task automatic test_reset_mid;
    apply_reset();
    m_if.waitrequest = 1'b1;
    drive(1, 1, 0, 32'h600, 0);
    step();
    @(negedge clk);
    checks++;
    if (grant !== 2'b10 || m_if.read !== 1'b1) begin errors++; $display("FAIL rmid_own: got grant=%b read=%b expected 10/1", grant, m_if.read); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (m_if.read !== 1'b0 || grant !== 2'b00 || r1_if.waitrequest !== 1'b1) begin
      errors++; $display("FAIL rmid_drop: got read=%b grant=%b wait1=%b expected 0/00/1", m_if.read, grant, r1_if.waitrequest);
    end
    step();
    reset_n = 1'b1;
    m_if.waitrequest = 1'b0;
    m_if.readdata = 32'h600D_600D;
    drive(0, 1, 0, 32'h610, 0);
    drive(1, 1, 0, 32'h620, 0);
    sb.push_back('{1'b0, 32'h610, 1'b0, 32'h0, 32'h600D_600D});
    @(negedge clk);
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL rmid_idle: got %b expected 00", grant); end
    step();
    @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL rmid_r0_first: got %b expected 01", grant); end
    step();
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    step();
    step();
  endtask

  task automatic test_wdog;
    apply_reset();
    m_if.waitrequest = 1'b1;
    m_if.readdata = 32'h55AA_55AA;
    drive(0, 1, 0, 32'h500, 0);
    for (int c = 1; c <= 11; c++) begin
      if (c == 10) drive(0, 0, 0, 0, 0);
      @(negedge clk);
`ifdef OPENETH_ARB_WDOG_EN
      if (c >= 2 && c <= 8) begin
        checks++;
        if (r0_if.waitrequest !== 1'b1 || r0_err !== 1'b0 || m_if.read !== 1'b1) begin
          errors++; $display("FAIL wdog_stall c%0d: got wait=%b err=%b read=%b expected 1/0/1", c, r0_if.waitrequest, r0_err, m_if.read);
        end
      end
      if (c == 9) begin
        checks++;
        if (r0_if.waitrequest !== 1'b0 || r0_if.readdata !== 32'hDEADBEEF || r0_err !== 1'b1 || m_if.read !== 1'b0) begin
          errors++; $display("FAIL wdog_abort: got wait=%b rd=%h err=%b read=%b expected 0/deadbeef/1/0",
                             r0_if.waitrequest, r0_if.readdata, r0_err, m_if.read);
        end
      end
      if (c == 10) begin
        checks++;
        if (grant !== 2'b00 || r0_err !== 1'b0) begin errors++; $display("FAIL wdog_idle: got grant=%b err=%b expected 00/0", grant, r0_err); end
      end
`else
      if (c >= 2 && c <= 9) begin
        checks++;
        if (r0_if.waitrequest !== 1'b1 || r0_err !== 1'b0 || m_if.read !== 1'b1) begin
          errors++; $display("FAIL nowdog_stall c%0d: got wait=%b err=%b read=%b expected 1/0/1", c, r0_if.waitrequest, r0_err, m_if.read);
        end
      end
      if (c == 10) begin
        checks++;
        if (grant !== 2'b01 || m_if.read !== 1'b0) begin errors++; $display("FAIL nowdog_drop: got grant=%b read=%b expected 01/0", grant, m_if.read); end
      end
`endif
      if (c == 11) begin
        checks++;
        if (grant !== 2'b00) begin errors++; $display("FAIL wdog_end_idle: got %b expected 00", grant); end
      end
      step();
    end
  endtask

  task automatic test_isolation;
    logic [1:0] eg [8] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
    apply_reset();
    m_if.waitrequest = 1'b1;
    m_if.readdata = 32'hFACE_FACE;
    drive(0, 0, 1, 32'h800, 32'h1111_0000);
    drive(1, 0, 1, 32'h900, 32'h7777_7777);
    sb.push_back('{1'b0, 32'h800, 1'b1, 32'h1111_0000, 32'h0});
    sb.push_back('{1'b1, 32'h900, 1'b1, 32'h7777_7777, 32'h0});
    for (int c = 1; c <= 8; c++) begin
      if (c == 5) m_if.waitrequest = 1'b0;
      if (c == 6) drive(0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (grant !== eg[c-1]) begin errors++; $display("FAIL iso_grant c%0d: got %b expected %b", c, grant, eg[c-1]); end
      if (c <= 7) begin
        checks++;
        if (r1_if.waitrequest !== 1'b1 || r1_if.readdata !== 32'h0 || m_if.writedata === 32'h7777_7777) begin
          errors++; $display("FAIL iso_r1 c%0d: got wait=%b rd=%h wd=%h", c, r1_if.waitrequest, r1_if.readdata, m_if.writedata);
        end
      end else begin
        checks++;
        if (m_if.writedata !== 32'h7777_7777) begin errors++; $display("FAIL iso_r1_data: got %h expected 77777777", m_if.writedata); end
      end
      step();
    end
    drive(1, 0, 0, 0, 0);
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    m_if.waitrequest = 1'b0;
    m_if.readdata = 32'h0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    test_reset();
    test_single();
    test_contention();
    test_burst();
    test_reset_mid();
    test_wdog();
    test_isolation();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
